// File: rtl/sd_host_regbank.sv
// Multi-slot SD host register bank: CPU req/ack access, W1C interrupt status,
// command-start pulses and per-slot irq. Define SD_REGBANK_ADMA64_EN for 64-bit ADMA addresses.
module sd_host_regbank #(
  parameter int NUM_SLOTS = 1,
  parameter int ADDR_W    = 12
) (
  input  logic                      CLK,
  input  logic                      rst_L,
  input  logic                      req,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [31:0]               wr_data,
  input  logic [3:0]                wr_be,
  output logic [31:0]               rd_data,
  output logic                      ack,
  input  logic [32*NUM_SLOTS-1:0]   hw_psr,
  input  logic [16*NUM_SLOTS-1:0]   hw_nisr_set,
  input  logic [16*NUM_SLOTS-1:0]   hw_eisr_set,
  input  logic [NUM_SLOTS-1:0]      hw_resp_wr,
  input  logic [32*NUM_SLOTS-1:0]   hw_resp_data,
  input  logic [NUM_SLOTS-1:0]      hw_blk_dec,
  output logic [12*NUM_SLOTS-1:0]   blk_size,
  output logic [16*NUM_SLOTS-1:0]   blk_cnt,
  output logic [32*NUM_SLOTS-1:0]   cmd_arg,
  output logic [16*NUM_SLOTS-1:0]   xfer_mode,
  output logic [16*NUM_SLOTS-1:0]   cmd_reg,
  output logic [64*NUM_SLOTS-1:0]   adma_addr,
  output logic [NUM_SLOTS-1:0]      cmd_start,
  output logic [NUM_SLOTS-1:0]      irq
);
  localparam int SLOT_W = ADDR_W - 8;
  localparam logic [5:0] OFF_BLK = 6'h01, OFF_ARG = 6'h02, OFF_CMD = 6'h03, OFF_RESP = 6'h04,
                         OFF_PSR = 6'h09, OFF_ISR = 6'h0C, OFF_IER = 6'h0D,
                         OFF_ADL = 6'h16, OFF_ADH = 6'h17;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
  state_t state, state_nxt;

  logic                       accept, wr_acc;
  logic [SLOT_W-1:0]          slot_idx;
  logic [5:0]                 offset;
  logic [31:0]                be_mask, rd_sel;
  logic [NUM_SLOTS-1:0][31:0] slot_rd;
  logic                       unused_addr;

  assign slot_idx    = addr[ADDR_W-1:8];
  assign offset      = addr[7:2];
  assign be_mask     = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
  assign unused_addr = ^addr[1:0];
  assign wr_acc      = accept & wr_en;

  always_ff @(posedge CLK or negedge rst_L)
    if (!rst_L) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACK;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && req;
    ack    = (state == ACK);
  end

  // Unmapped slots fall through to 0.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot_idx == SLOT_W'(i)) rd_sel = slot_rd[i];
  end

  always_ff @(posedge CLK or negedge rst_L)
    if (!rst_L)                rd_data <= '0;
    else if (accept && !wr_en) rd_data <= rd_sel;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic        sel, cmd_inh, cr_ok, bcr_wr, irq_q, cs_q, unused_nisr15;
    logic [11:0] bsr_q;
    logic [15:0] bcr_q, tmr_q, cr_q, eisr_q;
    logic [14:0] nisr_q;
    logic [31:0] arg_q, resp_q, ier_q, adl_q, adh_q, w1c, rd_v;
    logic [31:0] blk_m, cmd_m, arg_m, ier_m, adl_m;

    assign sel     = wr_acc && (slot_idx == SLOT_W'(s));
    assign cmd_inh = hw_psr[s*32];
    assign cr_ok   = sel && (offset == OFF_CMD) && !cmd_inh;
    assign bcr_wr  = sel && (offset == OFF_BLK) && |wr_be[3:2];
    assign blk_m   = ({bcr_q, 4'h0, bsr_q} & ~be_mask) | (wr_data & be_mask);
    assign cmd_m   = ({cr_q, tmr_q} & ~be_mask) | (wr_data & be_mask);
    assign arg_m   = (arg_q & ~be_mask) | (wr_data & be_mask);
    assign ier_m   = (ier_q & ~be_mask) | (wr_data & be_mask);
    assign adl_m   = (adl_q & ~be_mask) | (wr_data & be_mask);
    assign w1c     = (sel && offset == OFF_ISR) ? (wr_data & be_mask) : '0;
    assign unused_nisr15 = hw_nisr_set[s*16+15];

    always_ff @(posedge CLK or negedge rst_L)
      if (!rst_L) begin
        bsr_q <= '0; bcr_q <= '0; arg_q <= '0; tmr_q <= '0; cr_q <= '0; resp_q <= '0;
        nisr_q <= '0; eisr_q <= '0; ier_q <= '0; adl_q <= '0; irq_q <= 1'b0; cs_q <= 1'b0;
      end else begin
        if (sel && offset == OFF_BLK) bsr_q <= blk_m[11:0];
        // CPU write to BCR takes priority over a concurrent decrement.
        if (bcr_wr)                          bcr_q <= blk_m[31:16];
        else if (hw_blk_dec[s] && bcr_q != 0) bcr_q <= bcr_q - 16'd1;
        if (sel && offset == OFF_ARG) arg_q <= arg_m;
        if (sel && offset == OFF_CMD) tmr_q <= cmd_m[15:0];
        if (cr_ok)                    cr_q  <= cmd_m[31:16];
        if (hw_resp_wr[s])            resp_q <= hw_resp_data[s*32 +: 32];
        // Set is OR'ed after the clear so a coincident set wins.
        nisr_q <= (nisr_q & ~w1c[14:0])  | hw_nisr_set[s*16 +: 15];
        eisr_q <= (eisr_q & ~w1c[31:16]) | hw_eisr_set[s*16 +: 16];
        if (sel && offset == OFF_IER) ier_q <= ier_m;
        if (sel && offset == OFF_ADL) adl_q <= adl_m;
        irq_q <= |(nisr_q & ier_q[14:0]) | |(eisr_q & ier_q[31:16]);
        cs_q  <= cr_ok && wr_be[3];
      end

`ifdef SD_REGBANK_ADMA64_EN
    always_ff @(posedge CLK or negedge rst_L)
      if (!rst_L)                         adh_q <= '0;
      else if (sel && offset == OFF_ADH)  adh_q <= (adh_q & ~be_mask) | (wr_data & be_mask);
`else
    assign adh_q = '0;
`endif

    always_comb begin
      rd_v = '0;
      case (offset)
        OFF_BLK:  rd_v = {bcr_q, 4'h0, bsr_q};
        OFF_ARG:  rd_v = arg_q;
        OFF_CMD:  rd_v = {cr_q, tmr_q};
        OFF_RESP: rd_v = resp_q;
        OFF_PSR:  rd_v = hw_psr[s*32 +: 32];
        OFF_ISR:  rd_v = {eisr_q, |eisr_q, nisr_q};
        OFF_IER:  rd_v = ier_q;
        OFF_ADL:  rd_v = adl_q;
        OFF_ADH:  rd_v = adh_q;
        default:  rd_v = '0;
      endcase
    end

    assign slot_rd[s]             = rd_v;
    assign blk_size[s*12 +: 12]   = bsr_q;
    assign blk_cnt[s*16 +: 16]    = bcr_q;
    assign cmd_arg[s*32 +: 32]    = arg_q;
    assign xfer_mode[s*16 +: 16]  = tmr_q;
    assign cmd_reg[s*16 +: 16]    = cr_q;
    assign adma_addr[s*64 +: 64]  = {adh_q, adl_q};
    assign cmd_start[s]           = cs_q;
    assign irq[s]                 = irq_q;
  end
endmodule
